// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC read/write sequencers: state encoding,
// register addresses, command bytes and the per-step address lookup.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEG  = 3'd1,
    ST_MIN  = 3'd2,
    ST_HORA = 3'd3,
    ST_DIA  = 3'd4,
    ST_MES  = 3'd5,
    ST_ANO  = 3'd6,
    ST_CMD  = 3'd7
  } state_t;

  localparam logic [7:0] ADDR_CLK_SEG  = 8'h21;
  localparam logic [7:0] ADDR_CLK_MIN  = 8'h22;
  localparam logic [7:0] ADDR_CLK_HORA = 8'h23;
  localparam logic [7:0] ADDR_CLK_DIA  = 8'h24;
  localparam logic [7:0] ADDR_CLK_MES  = 8'h25;
  localparam logic [7:0] ADDR_CLK_ANO  = 8'h26;

  localparam logic [7:0] ADDR_TMR_SEG  = 8'h41;
  localparam logic [7:0] ADDR_TMR_MIN  = 8'h42;
  localparam logic [7:0] ADDR_TMR_HORA = 8'h43;

  localparam logic [7:0] CMD_CLK   = 8'hF1;
  localparam logic [7:0] CMD_TMR   = 8'hF2;
  localparam logic [7:0] IDLE_BYTE = 8'hFF;
  localparam logic [7:0] CMD_DATA  = 8'h01;

  // Address byte presented during the address phase of a write step.
  function automatic logic [7:0] step_addr(input state_t st, input logic clk_mode);
    logic [7:0] a;
    a = IDLE_BYTE;
    case (st)
      ST_SEG:  a = clk_mode ? ADDR_CLK_SEG  : ADDR_TMR_SEG;
      ST_MIN:  a = clk_mode ? ADDR_CLK_MIN  : ADDR_TMR_MIN;
      ST_HORA: a = clk_mode ? ADDR_CLK_HORA : ADDR_TMR_HORA;
      ST_DIA:  a = ADDR_CLK_DIA;
      ST_MES:  a = ADDR_CLK_MES;
      ST_ANO:  a = ADDR_CLK_ANO;
      ST_CMD:  a = clk_mode ? CMD_CLK : CMD_TMR;
      default: a = IDLE_BYTE;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_write_sequencer_bcd_sanitize.sv
// Two-nibble BCD clamp: any nibble above 9 becomes 0.
module bcd_sanitize (
  input  logic [7:0] raw,
  output logic [7:0] clean
);

  assign clean[7:4] = (raw[7:4] > 4'd9) ? 4'd0 : raw[7:4];
  assign clean[3:0] = (raw[3:0] > 4'd9) ? 4'd0 : raw[3:0];

endmodule

// File: rtl/rtc_write_sequencer.sv
// RTC register-write sequencer: walks the time fields (clock or timer set),
// answering address/data/advance strobes from the bus-timing controller.
module rtc_write_sequencer
  import rtc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       escritura,
  input  logic       en_clk,
  input  logic       dir_stb,
  input  logic       dat_stb,
  input  logic       cambio_estado,
  input  logic [7:0] seg_in,
  input  logic [7:0] min_in,
  input  logic [7:0] hora_in,
  input  logic [7:0] dia_in,
  input  logic [7:0] mes_in,
  input  logic [7:0] ano_in,
  output logic [7:0] dir_w,
  output logic [7:0] dato_w,
  output logic       e_escr,
  output logic       term_escr,
  output state_t     dbg_state
);

  // Strobe handshake: in a write state, dir_stb loads the address byte,
  // otherwise dat_stb loads the data byte, otherwise cambio_estado advances.
  // Lower-priority strobes in the same cycle are dropped, not deferred.

  state_t     state, state_nxt;
  logic       en_clk_q;
  logic [7:0] seg_q, min_q, hora_q, dia_q, mes_q, ano_q;
  logic [7:0] seg_s, min_s, hora_s, dia_s, mes_s, ano_s;
  logic [7:0] cur_data;
  logic [7:0] dir_nxt, dato_nxt;
  logic       e_nxt, term_nxt;
  logic       start, advance;

  assign start     = (state == ST_IDLE) && escritura;
  assign advance   = !dir_stb && !dat_stb && cambio_estado;
  assign dbg_state = state;

  bcd_sanitize u_san_seg  (.raw(seg_in),  .clean(seg_s));
  bcd_sanitize u_san_min  (.raw(min_in),  .clean(min_s));
  bcd_sanitize u_san_hora (.raw(hora_in), .clean(hora_s));
  bcd_sanitize u_san_dia  (.raw(dia_in),  .clean(dia_s));
  bcd_sanitize u_san_mes  (.raw(mes_in),  .clean(mes_s));
  bcd_sanitize u_san_ano  (.raw(ano_in),  .clean(ano_s));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (escritura) state_nxt = ST_SEG;
      ST_SEG:  if (advance)   state_nxt = ST_MIN;
      ST_MIN:  if (advance)   state_nxt = ST_HORA;
      ST_HORA: if (advance)   state_nxt = en_clk_q ? ST_DIA : ST_CMD;
      ST_DIA:  if (advance)   state_nxt = ST_MES;
      ST_MES:  if (advance)   state_nxt = ST_ANO;
      ST_ANO:  if (advance)   state_nxt = ST_CMD;
      ST_CMD:  if (advance)   state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Shadow copies hold the sanitised fields for the whole sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_clk_q <= 1'b0;
      seg_q    <= 8'h00;
      min_q    <= 8'h00;
      hora_q   <= 8'h00;
      dia_q    <= 8'h00;
      mes_q    <= 8'h00;
      ano_q    <= 8'h00;
    end else if (start) begin
      en_clk_q <= en_clk;
      seg_q    <= seg_s;
      min_q    <= min_s;
      hora_q   <= hora_s;
      dia_q    <= dia_s;
      mes_q    <= mes_s;
      ano_q    <= ano_s;
    end
  end

  always_comb begin
    cur_data = IDLE_BYTE;
    case (state)
      ST_SEG:  cur_data = seg_q;
      ST_MIN:  cur_data = min_q;
      ST_HORA: cur_data = hora_q;
      ST_DIA:  cur_data = dia_q;
      ST_MES:  cur_data = mes_q;
      ST_ANO:  cur_data = ano_q;
      ST_CMD:  cur_data = CMD_DATA;
      default: cur_data = IDLE_BYTE;
    endcase
  end

  // Output values are decided from the next state so every output is a
  // plain register and e_escr never dips between steps.
  always_comb begin
    dir_nxt  = dir_w;
    dato_nxt = dato_w;
    e_nxt    = 1'b1;
    term_nxt = 1'b0;
    if (state_nxt == ST_IDLE) begin
      dir_nxt  = IDLE_BYTE;
      dato_nxt = IDLE_BYTE;
      e_nxt    = 1'b0;
      term_nxt = (state == ST_CMD);
    end else if (state != ST_IDLE) begin
      if (dir_stb) begin
        dir_nxt = step_addr(state, en_clk_q);
      end else if (dat_stb) begin
        dato_nxt = cur_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_w     <= IDLE_BYTE;
      dato_w    <= IDLE_BYTE;
      e_escr    <= 1'b0;
      term_escr <= 1'b0;
    end else begin
      dir_w     <= dir_nxt;
      dato_w    <= dato_nxt;
      e_escr    <= e_nxt;
      term_escr <= term_nxt;
    end
  end

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Bench for rtc_write_sequencer: table-driven full sequences plus
// hand-written corner sequences (sanitise, priority, reset, back-to-back).
module tb_rtc_write_sequencer;
  import rtc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       escritura, en_clk, dir_stb, dat_stb, cambio_estado;
  logic [7:0] seg_in, min_in, hora_in, dia_in, mes_in, ano_in;
  logic [7:0] dir_w, dato_w;
  logic       e_escr, term_escr;
  state_t     dbg_state;

  typedef struct {
    logic       esc;
    logic       en;
    logic       ds;
    logic       dt;
    logic       cs;
    logic [7:0] dir;
    logic [7:0] dato;
    logic       e;
    logic       term;
  } vec_t;

  vec_t        tbl[$];
  logic [17:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  rtc_write_sequencer dut (
    .clk(clk), .reset(reset), .escritura(escritura), .en_clk(en_clk),
    .dir_stb(dir_stb), .dat_stb(dat_stb), .cambio_estado(cambio_estado),
    .seg_in(seg_in), .min_in(min_in), .hora_in(hora_in),
    .dia_in(dia_in), .mes_in(mes_in), .ano_in(ano_in),
    .dir_w(dir_w), .dato_w(dato_w), .e_escr(e_escr), .term_escr(term_escr),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_st(input string name, input state_t exp);
    n_vec++;
    if (dbg_state !== exp) begin
      n_err++;
      $display("FAIL %s: state got %0d expected %0d", name, dbg_state, exp);
    end
  endtask

  task automatic drive(input logic esc, input logic en, input logic ds,
                       input logic dt, input logic cs);
    escritura     = esc;
    en_clk        = en;
    dir_stb       = ds;
    dat_stb       = dt;
    cambio_estado = cs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic esc, input logic en, input logic ds, input logic dt,
                     input logic cs, input logic [7:0] dir, input logic [7:0] dato,
                     input logic e, input logic term);
    vec_t v;
    v.esc = esc; v.en = en; v.ds = ds; v.dt = dt; v.cs = cs;
    v.dir = dir; v.dato = dato; v.e = e; v.term = term;
    tbl.push_back(v);
  endtask

  // One register step: address phase, data phase, advance.
  task automatic add_step(input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] prev, input logic last);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, prev, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a, d, 1'b1, 1'b0);
    if (last) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
    else      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, d, 1'b1, 1'b0);
  endtask

  task automatic scramble_fields();
    seg_in  = 8'($urandom_range(0, 255));
    min_in  = 8'($urandom_range(0, 255));
    hora_in = 8'($urandom_range(0, 255));
    dia_in  = 8'($urandom_range(0, 255));
    mes_in  = 8'($urandom_range(0, 255));
    ano_in  = 8'($urandom_range(0, 255));
  endtask

  // Drive each vector, queue its expectation, pop and compare after the edge.
  // Field inputs are scrambled after the start edge to prove shadowing.
  task automatic run_table(input string tag);
    logic [17:0] exp;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].esc, tbl[i].en, tbl[i].ds, tbl[i].dt, tbl[i].cs);
      exp_q.push_back({tbl[i].dir, tbl[i].dato, tbl[i].e, tbl[i].term});
      tick();
      if (i == 0) scramble_fields();
      exp = exp_q.pop_front();
      check8($sformatf("%s[%0d] dir_w", tag, i), dir_w, exp[17:10]);
      check8($sformatf("%s[%0d] dato_w", tag, i), dato_w, exp[9:2]);
      check1($sformatf("%s[%0d] e_escr", tag, i), e_escr, exp[1]);
      check1($sformatf("%s[%0d] term_escr", tag, i), term_escr, exp[0]);
    end
    tbl.delete();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    seg_in = 8'h00; min_in = 8'h00; hora_in = 8'h00;
    dia_in = 8'h00; mes_in = 8'h00; ano_in = 8'h00;
    tick();
    tick();
    check8("reset dir_w", dir_w, 8'hFF);
    check8("reset dato_w", dato_w, 8'hFF);
    check1("reset e_escr", e_escr, 1'b0);
    check1("reset term_escr", term_escr, 1'b0);
    check_st("reset state", ST_IDLE);
    reset = 1'b0;
    tick();

    // Full clock write.
    seg_in = 8'h45; min_in = 8'h30; hora_in = 8'h12;
    dia_in = 8'h25; mes_in = 8'h12; ano_in = 8'h16;
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
    add_step(8'h21, 8'h45, 8'hFF, 1'b0);
    add_step(8'h22, 8'h30, 8'h45, 1'b0);
    add_step(8'h23, 8'h12, 8'h30, 1'b0);
    add_step(8'h24, 8'h25, 8'h12, 1'b0);
    add_step(8'h25, 8'h12, 8'h25, 1'b0);
    add_step(8'h26, 8'h16, 8'h12, 1'b0);
    add_step(8'hF1, 8'h01, 8'h16, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    run_table("clk");

    // Timer write: HORA goes straight to CMD.
    seg_in = 8'h05; min_in = 8'h10; hora_in = 8'h01;
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
    add_step(8'h41, 8'h05, 8'hFF, 1'b0);
    add_step(8'h42, 8'h10, 8'h05, 1'b0);
    add_step(8'h43, 8'h01, 8'h10, 1'b0);
    add_step(8'hF2, 8'h01, 8'h01, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    run_table("tmr");

    // Sanitise and stability.
    seg_in = 8'h7B; min_in = 8'hA3;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check_st("san start state", ST_SEG);
    check1("san start e_escr", e_escr, 1'b1);
    seg_in = 8'h00; min_in = 8'h00;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    check8("san seg dir_w", dir_w, 8'h21);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    check8("san seg dato_w", dato_w, 8'h70);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    check_st("san adv state", ST_MIN);

    // Priority: lower strobes dropped.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1); tick();
    check8("prio dir_w", dir_w, 8'h22);
    check_st("prio dir state", ST_MIN);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    check8("prio min dato_w", dato_w, 8'h03);
    check_st("prio dat state", ST_MIN);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    check_st("prio adv state", ST_HORA);

    // Start request ignored while busy.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    check_st("ignore state", ST_HORA);
    check1("ignore e_escr", e_escr, 1'b1);
    check8("ignore dir_w", dir_w, 8'h22);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    check_st("latched mode state", ST_DIA);
    tick();
    check_st("to mes state", ST_MES);

    // Asynchronous reset in MES.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check8("rst mes dir_w", dir_w, 8'hFF);
    check8("rst mes dato_w", dato_w, 8'hFF);
    check1("rst mes e_escr", e_escr, 1'b0);
    check1("rst mes term_escr", term_escr, 1'b0);
    check_st("rst mes state", ST_IDLE);
    tick();
    check1("rst hold term_escr", term_escr, 1'b0);
    reset = 1'b0;
    tick();
    check1("post rst term_escr", term_escr, 1'b0);

    // Restart after reset, timer mode, run to CMD.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    check_st("restart state", ST_SEG);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    check8("restart dir_w", dir_w, 8'h41);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    tick();
    tick();
    check_st("restart cmd state", ST_CMD);

    // Back-to-back: escritura held through the completion pulse.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    check1("b2b term_escr", term_escr, 1'b1);
    check1("b2b done e_escr", e_escr, 1'b0);
    check8("b2b done dir_w", dir_w, 8'hFF);
    check_st("b2b idle state", ST_IDLE);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check1("b2b term low", term_escr, 1'b0);
    check1("b2b e_escr", e_escr, 1'b1);
    check_st("b2b seg state", ST_SEG);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    check8("b2b dir_w", dir_w, 8'h21);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
